// File: rtl/station_cmd_cntrl.sv
// Go/stop command sequencer: latches a destination station, consumes barcode IDs
// and gates motion; optional piezo tone while obstructed (compile with PIEZO_BUZZ_EN).
module station_cmd_cntrl #(
   parameter int BUZZ_DIV = 12500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd,
   input  logic       cmd_rdy,
   output logic       clr_cmd_rdy,
   input  logic [7:0] ID,
   input  logic       ID_vld,
   output logic       clr_ID_vld,
   input  logic       OK2Move,
   output logic       go,
   output logic       in_transit,
   output logic       buzz,
   output logic       buzz_n
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MOVE = 1'b1;
   localparam logic [1:0] OP_STOP = 2'b00;
   localparam logic [1:0] OP_GO   = 2'b01;

   if (BUZZ_DIV < 2) begin : g_bad_div
      $error("BUZZ_DIV must be at least 2");
   end

   logic [0:0] state, nxt_state;
   logic [5:0] dest_ID, nxt_dest_ID;
   logic       nxt_in_transit;

   // The reader already qualifies ID integrity, so only the low six bits matter.
   logic unused_id_hi;
   assign unused_id_hi = ^ID[7:6];

   always_comb begin
      clr_cmd_rdy    = 1'b0;
      clr_ID_vld     = 1'b0;
      nxt_state      = state;
      nxt_dest_ID    = dest_ID;
      nxt_in_transit = in_transit;
      case (state)
         IDLE: begin
            if (cmd_rdy) begin
               clr_cmd_rdy = 1'b1;
               if (cmd[7:6] == OP_GO) begin
                  nxt_dest_ID    = cmd[5:0];
                  nxt_in_transit = 1'b1;
                  nxt_state      = MOVE;
               end
            end else if (ID_vld) begin
               clr_ID_vld = 1'b1;
            end
         end
         MOVE: begin
            if (cmd_rdy) begin
               clr_cmd_rdy = 1'b1;
               case (cmd[7:6])
                  OP_GO:   nxt_dest_ID = cmd[5:0];
                  OP_STOP: begin
                     nxt_in_transit = 1'b0;
                     nxt_state      = IDLE;
                  end
                  default: ;
               endcase
            end else if (ID_vld) begin
               clr_ID_vld = 1'b1;
               if (ID[5:0] == dest_ID) begin
                  nxt_in_transit = 1'b0;
                  nxt_state      = IDLE;
               end
            end
         end
         default: begin
            nxt_state      = IDLE;
            nxt_in_transit = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dest_ID    <= 6'h00;
         in_transit <= 1'b0;
      end else begin
         state      <= nxt_state;
         dest_ID    <= nxt_dest_ID;
         in_transit <= nxt_in_transit;
      end
   end

   assign go = in_transit & OK2Move;

`ifdef PIEZO_BUZZ_EN
   localparam int CW = $clog2(BUZZ_DIV);

   logic [CW-1:0] buzz_cnt;
   logic          blocked;
   assign blocked = in_transit & ~OK2Move;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buzz_cnt <= '0;
         buzz     <= 1'b0;
      end else if (!blocked) begin
         buzz_cnt <= '0;
         buzz     <= 1'b0;
      end else if (buzz_cnt == CW'(BUZZ_DIV - 1)) begin
         buzz_cnt <= '0;
         buzz     <= ~buzz;
      end else begin
         buzz_cnt <= buzz_cnt + 1'b1;
      end
   end
`else
   assign buzz = 1'b0;
`endif

   assign buzz_n = ~buzz;

endmodule

// File: tb/tb_station_cmd_cntrl.sv
// Directed bench for station_cmd_cntrl (BUZZ_DIV=4); buzzer checks follow PIEZO_BUZZ_EN.
module tb_station_cmd_cntrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       cmd_rdy = 1'b0;
   logic       clr_cmd_rdy;
   logic [7:0] ID = 8'h00;
   logic       ID_vld = 1'b0;
   logic       clr_ID_vld;
   logic       OK2Move = 1'b1;
   logic       go, in_transit, buzz, buzz_n;

   int n_vec = 0;
   int n_err = 0;

   station_cmd_cntrl #(.BUZZ_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
      .go(go), .in_transit(in_transit), .buzz(buzz), .buzz_n(buzz_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h @%0t", tag, act, exp, $time);
      end
   endtask

   // advance one edge, then settle 1ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present cmd, check it is consumed this cycle, then let the source drop cmd_rdy
   task automatic send_cmd(input string tag, input logic [7:0] c);
      cmd = c; cmd_rdy = 1'b1;
      #1 chk({tag, "_clr_cmd"}, {7'b0, clr_cmd_rdy}, 8'd1);
      chk({tag, "_no_clr_id"}, {7'b0, clr_ID_vld}, 8'd0);
      tick();
      cmd_rdy = 1'b0;
      #1;
   endtask

   task automatic send_id(input string tag, input logic [7:0] i);
      ID = i; ID_vld = 1'b1;
      #1 chk({tag, "_clr_id"}, {7'b0, clr_ID_vld}, 8'd1);
      chk({tag, "_no_clr_cmd"}, {7'b0, clr_cmd_rdy}, 8'd0);
      tick();
      ID_vld = 1'b0;
      #1;
   endtask

   logic exp_bz;

   initial begin
      #3;
      chk("rst_in_transit", {7'b0, in_transit}, 8'd0);
      chk("rst_go", {7'b0, go}, 8'd0);
      chk("rst_buzz", {7'b0, buzz}, 8'd0);
      chk("rst_buzz_n", {7'b0, buzz_n}, 8'd1);
      chk("rst_clr_cmd", {7'b0, clr_cmd_rdy}, 8'd0);
      chk("rst_clr_id", {7'b0, clr_ID_vld}, 8'd0);
      #10 rst_n = 1'b1;
      tick();

      // go to station 5
      chk("pre_go_in_transit", {7'b0, in_transit}, 8'd0);
      send_cmd("go45", 8'h45);
      chk("go45_in_transit", {7'b0, in_transit}, 8'd1);
      chk("go45_go", {7'b0, go}, 8'd1);
      chk("go45_clr_done", {7'b0, clr_cmd_rdy}, 8'd0);

      send_id("id03", 8'h03);
      chk("id03_still_moving", {7'b0, in_transit}, 8'd1);
      send_id("id05", 8'h05);
      chk("id05_arrived", {7'b0, in_transit}, 8'd0);
      chk("id05_go", {7'b0, go}, 8'd0);

      // stop and ID in the same cycle: cmd wins, ID handled next in IDLE
      send_cmd("go45b", 8'h45);
      chk("go45b_in_transit", {7'b0, in_transit}, 8'd1);
      cmd = 8'h00; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1;
      #1 chk("both_clr_cmd", {7'b0, clr_cmd_rdy}, 8'd1);
      chk("both_no_clr_id", {7'b0, clr_ID_vld}, 8'd0);
      tick();
      cmd_rdy = 1'b0;
      #1 chk("both_stopped", {7'b0, in_transit}, 8'd0);
      chk("both_id_pending_clr", {7'b0, clr_ID_vld}, 8'd1);
      chk("both_no_second_cmd", {7'b0, clr_cmd_rdy}, 8'd0);
      tick();
      ID_vld = 1'b0;
      #1 chk("both_idle", {7'b0, in_transit}, 8'd0);

      // retarget in flight; ID[7:6] must be ignored on match
      send_cmd("go45c", 8'h45);
      send_cmd("retgt4A", 8'h4A);
      chk("retgt_moving", {7'b0, in_transit}, 8'd1);
      send_id("old05", 8'h05);
      chk("old05_ignored", {7'b0, in_transit}, 8'd1);
      send_id("new8A", 8'h8A);
      chk("new8A_arrived", {7'b0, in_transit}, 8'd0);

      // reserved opcodes discarded in both states
      send_cmd("rsv_idle", 8'h85);
      chk("rsv_idle_stays", {7'b0, in_transit}, 8'd0);
      send_cmd("go41", 8'h41);
      send_cmd("rsv_move", 8'hC1);
      chk("rsv_move_stays", {7'b0, in_transit}, 8'd1);

      // obstruction: tone with period 8 cycles
      OK2Move = 1'b0;
      #1 chk("blk_go", {7'b0, go}, 8'd0);
      for (int k = 1; k <= 12; k++) begin
         tick();
`ifdef PIEZO_BUZZ_EN
         exp_bz = ((k / 4) % 2) == 1;
`else
         exp_bz = 1'b0;
`endif
         chk($sformatf("buzz_k%0d", k), {7'b0, buzz}, {7'b0, exp_bz});
         chk($sformatf("buzz_n_k%0d", k), {7'b0, buzz_n}, {7'b0, ~exp_bz});
      end
      OK2Move = 1'b1;
      #1 chk("clear_go", {7'b0, go}, 8'd1);
      tick();
      chk("clear_buzz", {7'b0, buzz}, 8'd0);
      chk("clear_buzz_n", {7'b0, buzz_n}, 8'd1);

      // async reset while buzzing
      OK2Move = 1'b0;
      for (int k = 0; k < 5; k++) tick();
`ifdef PIEZO_BUZZ_EN
      chk("pre_rst_buzz", {7'b0, buzz}, 8'd1);
`endif
      #2 rst_n = 1'b0;
      #1 chk("arst_in_transit", {7'b0, in_transit}, 8'd0);
      chk("arst_go", {7'b0, go}, 8'd0);
      chk("arst_buzz", {7'b0, buzz}, 8'd0);
      chk("arst_buzz_n", {7'b0, buzz_n}, 8'd1);
      #4 rst_n = 1'b1;
      OK2Move = 1'b1;
      tick();
      send_id("post_rst_id", 8'h41);
      chk("post_rst_no_motion", {7'b0, in_transit}, 8'd0);
      chk("post_rst_go", {7'b0, go}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
